// File: rtl/memory_stage.sv
// Memory stage of a five-stage pipeline: EX/MEM register, a data-memory access
// FSM with a bounded wait, and the MEM/WB register feeding writeback.
module memory_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic [4:0]   ctrl_E,
    input  logic [4:0]   rd_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    output logic         dm_read,
    output logic         dm_write,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         regWrite_W,
    output logic [4:0]   rd_W,
    output logic [N-1:0] result_W,
    output logic         err_M,
    output logic         state_dbg
);

    // Handshake: dm_read/dm_write act as valid and stay asserted, with address
    // and data stable, until dm_ack=1 or the access is abandoned; dm_ack is
    // only meaningful while a request strobe is high.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    // EX/MEM register
    logic         valid_q, valid_d;
    logic [4:0]   ctrl_q, ctrl_d;
    logic [4:0]   rd_q, rd_d;
    logic [N-1:0] alu_q, alu_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] pcb_q, pcb_d;
    logic         zero_q, zero_d;

    // Access FSM
    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         err_q, err_d;

    // MEM/WB register
    logic         wb_regwrite_q, wb_regwrite_d;
    logic [4:0]   wb_rd_q, wb_rd_d;
    logic [N-1:0] wb_result_q, wb_result_d;

    logic regwrite_m, memtoreg_m, memread_m, memwrite_m, branch_m;
    logic memop_m, rd_req, wr_req;
    logic stall, done;

    assign {regwrite_m, memtoreg_m, memread_m, memwrite_m, branch_m} = ctrl_q;

    // A read+write request is treated as a read.
    assign memop_m = valid_q & (memread_m | memwrite_m);
    assign rd_req  = memop_m & memread_m;
    assign wr_req  = memop_m & memwrite_m & ~memread_m;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        pcb_d   = pcb_q;
        zero_d  = zero_q;
        if (!stall) begin
            valid_d = valid_E;
            ctrl_d  = ctrl_E;
            rd_d    = rd_E;
            alu_d   = aluResult_E;
            wdata_d = writeData_E;
            pcb_d   = PCBranch_E;
            zero_d  = zero_E;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            pcb_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            pcb_q   <= pcb_d;
            zero_q  <= zero_d;
        end
    end

    // WAIT is only reachable with a held memory op, so dm_ack there always
    // belongs to the outstanding access; the last WAIT cycle drops the stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop_m) begin
                    if (dm_ack) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                if (dm_ack) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // An unstalled read is either completed (done) or abandoned; the latter
    // writes zero instead of stale bus data.
    always_comb begin
        wb_regwrite_d = 1'b0;
        wb_rd_d       = '0;
        wb_result_d   = '0;
        if (!stall) begin
            wb_regwrite_d = valid_q & regwrite_m;
            wb_rd_d       = rd_q;
            if (rd_req && memtoreg_m) begin
                wb_result_d = done ? dm_rdata : '0;
            end else begin
                wb_result_d = alu_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_result_q   <= '0;
        end else begin
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_result_q   <= wb_result_d;
        end
    end

    assign dm_addr    = alu_q;
    assign dm_wdata   = wdata_q;
    assign dm_read    = rd_req;
    assign dm_write   = wr_req;
    assign stall_M    = stall;
    assign PCSrc_M    = valid_q & branch_m & zero_q;
    assign PCBranch_M = pcb_q;
    assign regWrite_W = wb_regwrite_q;
    assign rd_W       = wb_rd_q;
    assign result_W   = wb_result_q;
    assign err_M      = err_q;
    assign state_dbg  = (state_q == S_WAIT);

endmodule
